// File: rtl/famicom_pkg.sv
// Shared definitions for the Famicom/NES pad serializer: button bit positions
// in the MiSTer joystick word and the pad-byte packing helper.
package famicom_pkg;

    localparam int BTN_R       = 0;
    localparam int BTN_L       = 1;
    localparam int BTN_D       = 2;
    localparam int BTN_U       = 3;
    localparam int BTN_A       = 4;
    localparam int BTN_B       = 5;
    localparam int BTN_SELECT  = 6;
    localparam int BTN_START   = 7;
    localparam int BTN_TURBO_A = 8;
    localparam int BTN_TURBO_B = 9;

    localparam int NES_BITS = 8;

    // Un-inverted pad byte {R,L,D,U,Start,Select,B,A}; A is shifted out first.
    function automatic logic [NES_BITS-1:0] nes_byte(
        input logic [15:0] joy16,
        input logic        phase,
        input logic        turbo_en
    );
        logic a_eff;
        logic b_eff;
        a_eff = joy16[BTN_A] | (turbo_en & joy16[BTN_TURBO_A] & phase);
        b_eff = joy16[BTN_B] | (turbo_en & joy16[BTN_TURBO_B] & phase);
        return {joy16[BTN_R], joy16[BTN_L], joy16[BTN_D], joy16[BTN_U],
                joy16[BTN_START], joy16[BTN_SELECT], b_eff, a_eff};
    endfunction

endpackage

// File: rtl/famicom_sync_edge.sv
// Multi-flop synchroniser for an asynchronous strobe from the Gigatron clock
// domain, followed by a one-flop edge detector.
module famicom_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/famicom_pad_serializer.sv
// Emulates NUM_PADS Famicom/NES serial controllers on clk_sys: latch loads the
// inverted pad bytes, each pulse rising edge shifts one bit out (1-filled).
module famicom_pad_serializer
    import famicom_pkg::*;
#(
    parameter int         NUM_PADS    = 2,
    parameter int         CHAIN       = 0,
    parameter logic [7:0] SIG_BYTE    = 8'h10,
    parameter int         SYNC_STAGES = 2,
    parameter int         TURBO_DIV   = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [NUM_PADS*16-1:0] joystick,
    input  logic                   famicom_latch,
    input  logic                   famicom_pulse,
    input  logic [NUM_PADS-1:0]    turbo_en,
    output logic [NUM_PADS-1:0]    famicom_data,
    output logic                   read_done
);

    localparam int TOTAL_BITS = (CHAIN != 0) ? NUM_PADS*NES_BITS + NES_BITS : NES_BITS;
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
    localparam int DIV_W      = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TURBO_DIV - 1);

    logic latch_level, latch_rise, latch_fall;
    logic pulse_level, pulse_rise, pulse_fall;

    famicom_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (famicom_latch),
        .level   (latch_level),
        .rise    (latch_rise),
        .fall    (latch_fall)
    );

    famicom_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (famicom_pulse),
        .level   (pulse_level),
        .rise    (pulse_rise),
        .fall    (pulse_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{latch_rise, pulse_level, pulse_fall, SIG_BYTE, joystick};

    // Latch wins over a coincident pulse edge.
    logic load;
    logic shift;
    assign load  = latch_level;
    assign shift = pulse_rise & ~latch_level;

    // Turbo phase advances on latch falling edges, i.e. only between reads.
    logic [DIV_W-1:0] turbo_div_cnt;
    logic             turbo_phase;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            turbo_div_cnt <= '0;
            turbo_phase   <= 1'b0;
        end else if (latch_fall) begin
            if (turbo_div_cnt == DIV_LAST) begin
                turbo_div_cnt <= '0;
                turbo_phase   <= ~turbo_phase;
            end else begin
                turbo_div_cnt <= turbo_div_cnt + 1'b1;
            end
        end
    end

    logic [NUM_PADS-1:0][NES_BITS-1:0] pad_inv;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad_byte
        assign pad_inv[p] = ~nes_byte(joystick[16*p +: 16], turbo_phase, turbo_en[p]);
    end

    if (CHAIN == 0) begin : g_parallel
        for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
            logic [NES_BITS-1:0] sr;
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    sr <= '1;
                end else if (load) begin
                    sr <= pad_inv[p];
                end else if (shift) begin
                    sr <= {1'b1, sr[NES_BITS-1:1]};
                end
            end
            assign famicom_data[p] = sr[0];
        end
    end else begin : g_chain
        logic [TOTAL_BITS-1:0] sr;
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                sr <= '1;
            end else if (load) begin
                sr <= {~SIG_BYTE, pad_inv};
            end else if (shift) begin
                sr <= {1'b1, sr[TOTAL_BITS-1:1]};
            end
        end
        assign famicom_data[0] = sr[0];
        for (genvar p = 1; p < NUM_PADS; p++) begin : g_idle_line
            assign famicom_data[p] = 1'b1;
        end
    end

    // Saturating bit counter; starts full so reset never produces read_done.
    logic [CNT_W-1:0] bit_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bit_cnt   <= CNT_FULL;
            read_done <= 1'b0;
        end else begin
            read_done <= 1'b0;
            if (load) begin
                bit_cnt <= '0;
            end else if (shift && (bit_cnt != CNT_FULL)) begin
                bit_cnt   <= bit_cnt + 1'b1;
                read_done <= (bit_cnt == CNT_LAST);
            end
        end
    end

endmodule

// File: tb/tb_famicom_pad_serializer.sv
// Scoreboarded bench: a parallel (CHAIN=0) and a daisy-chained (CHAIN=1)
// instance share latch/pulse/joystick; every settled read position is checked.
`timescale 1ns/1ps
module tb_famicom_pad_serializer;

    localparam int SYNC = 2;

    // clock / reset
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset    = 1'b1;
    logic        latch    = 1'b0;
    logic        pulse    = 1'b0;
    logic [31:0] joystick = '0;
    logic [1:0]  turbo_en = '0;
    logic [1:0]  data_a;
    logic [1:0]  data_b;
    logic        done_a;
    logic        done_b;

    famicom_pad_serializer #(
        .NUM_PADS(2), .CHAIN(0), .SIG_BYTE(8'h10), .SYNC_STAGES(SYNC), .TURBO_DIV(2)
    ) u_par (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .joystick      (joystick),
        .famicom_latch (latch),
        .famicom_pulse (pulse),
        .turbo_en      (turbo_en),
        .famicom_data  (data_a),
        .read_done     (done_a)
    );

    famicom_pad_serializer #(
        .NUM_PADS(2), .CHAIN(1), .SIG_BYTE(8'h10), .SYNC_STAGES(SYNC), .TURBO_DIV(2)
    ) u_chain (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .joystick      (joystick),
        .famicom_latch (latch),
        .famicom_pulse (pulse),
        .turbo_en      (turbo_en),
        .famicom_data  (data_b),
        .read_done     (done_b)
    );

    // scoreboard: {done_b_seen, done_a_seen, data_b[1:0], data_a[1:0]}
    logic [5:0] exp_q[$];
    string      name_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         req_cnt      = 0;
    int         served       = 0;
    logic       seen_a       = 1'b0;
    logic       seen_b       = 1'b0;
    logic [5:0] mon_act;
    logic [5:0] mon_exp;
    string      mon_name;

    // expected line contents (inverted bytes) and bit counters
    logic [7:0]  sh_a0 = 8'hFF;
    logic [7:0]  sh_a1 = 8'hFF;
    logic [23:0] sh_b  = 24'hFFFFFF;
    int          cnt_a = 8;
    int          cnt_b = 24;
    int          falls = 0;
    bit          jitter = 1'b0;

    always @(negedge clk_sys) begin
        if (done_a === 1'b1) seen_a = 1'b1;
        if (done_b === 1'b1) seen_b = 1'b1;
        if (served != req_cnt) begin
            mon_act = {seen_b, seen_a, data_b, data_a};
            served++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_underflow: got %b with no expectation queued", mon_act);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (mon_act !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %b expected %b (done_b,done_a,data_b,data_a)",
                             mon_name, mon_act, mon_exp);
                end
            end
            seen_a = 1'b0;
            seen_b = 1'b0;
        end
    end

    // driver tasks
    task automatic hold(input int n);
        repeat (n) @(posedge clk_sys);
        if (jitter) #($urandom_range(1, 9));
        else #1;
    endtask

    task automatic push_exp(input logic da, input logic db, input string nm);
        exp_q.push_back({db, da, 1'b1, sh_b[0], sh_a1[0], sh_a0[0]});
        name_q.push_back(nm);
        req_cnt++;
        for (int i = 0; i < 10 && served != req_cnt; i++) @(posedge clk_sys);
    endtask

    task automatic set_shadow(input logic [7:0] e0, input logic [7:0] e1, input logic [23:0] eb);
        sh_a0 = e0;
        sh_a1 = e1;
        sh_b  = eb;
        cnt_a = 0;
        cnt_b = 0;
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk_sys);
        #1 reset = 1'b1;
        hold(3);
        reset = 1'b0;
        sh_a0 = 8'hFF;
        sh_a1 = 8'hFF;
        sh_b  = 24'hFFFFFF;
        cnt_a = 8;
        cnt_b = 24;
        falls = 0;
        push_exp(1'b0, 1'b0, nm);
    endtask

    task automatic do_latch(input logic [7:0] e0, input logic [7:0] e1,
                            input logic [23:0] eb, input string nm);
        latch = 1'b1;
        hold(4);
        latch = 1'b0;
        hold(4);
        falls++;
        set_shadow(e0, e1, eb);
        push_exp(1'b0, 1'b0, nm);
    endtask

    task automatic do_pulse(input string nm);
        logic da;
        logic db;
        pulse = 1'b1;
        hold(4);
        pulse = 1'b0;
        hold(4);
        da = (cnt_a == 7);
        db = (cnt_b == 23);
        if (cnt_a < 8)  cnt_a++;
        if (cnt_b < 24) cnt_b++;
        sh_a0 = {1'b1, sh_a0[7:1]};
        sh_a1 = {1'b1, sh_a1[7:1]};
        sh_b  = {1'b1, sh_b[23:1]};
        push_exp(da, db, nm);
    endtask

    // reference pad byte {R,L,D,U,Start,Select,B,A}
    function automatic logic [7:0] pad_model(input logic [15:0] j, input logic ph, input logic te);
        logic a;
        logic b;
        a = j[4] | (te & j[8] & ph);
        b = j[5] | (te & j[9] & ph);
        return {j[0], j[1], j[2], j[3], j[7], j[6], b, a};
    endfunction

    logic [7:0] t3_exp [8] = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFE};

    initial begin : stimulus
        logic [7:0] e0;
        logic [7:0] e1;
        logic       ph;
        int         np;

        do_reset("reset_idle");

        // pulses before any latch shift in 1s only, no read_done
        do_pulse("prelatch_pulse");
        do_pulse("prelatch_pulse");

        // T1: R+A on pad0 -> line 0,1,1,1,1,1,1,0 then 1
        joystick = {16'h0000, 16'h0011};
        do_latch(8'h7E, 8'hFF, 24'hEFFF7E, "t1_latch");
        for (int k = 0; k < 10; k++) do_pulse("t1_pulse");

        // T2: pad0 Start, pad1 Up; chain stream {~10,~10,~08}
        joystick = {16'h0008, 16'h0080};
        do_latch(8'hF7, 8'hEF, 24'hEFEFF7, "t2_latch");
        for (int k = 0; k < 26; k++) do_pulse("t2_pulse");

        // T3: TurboA with TURBO_DIV=2, pad0 enabled, pad1 not
        do_reset("t3_reset");
        joystick = {16'h0100, 16'h0100};
        turbo_en = 2'b01;
        for (int f = 0; f < 8; f++)
            do_latch(t3_exp[f], 8'hFF, {8'hEF, 8'hFF, t3_exp[f]}, "t3_turbo_on");
        turbo_en = 2'b00;
        for (int f = 0; f < 4; f++)
            do_latch(8'hFF, 8'hFF, 24'hEFFFFF, "t3_turbo_off");

        // T4: latch high with pulse edges -> no shift; live joystick tracked
        joystick = {16'h0000, 16'h0001};
        latch = 1'b1;
        pulse = 1'b1;
        hold(4);
        pulse = 1'b0;
        hold(2);
        pulse = 1'b1;
        hold(2);
        pulse = 1'b0;
        hold(2);
        set_shadow(8'h7F, 8'hFF, 24'hEFFF7F);
        push_exp(1'b0, 1'b0, "t4_latched_no_shift");
        joystick[15:0] = 16'h0010;
        hold(SYNC + 2);
        set_shadow(8'hFE, 8'hFF, 24'hEFFFFE);
        push_exp(1'b0, 1'b0, "t4_live_track");
        latch = 1'b0;
        hold(4);
        falls++;
        for (int k = 0; k < 8; k++) do_pulse("t4_pulse");

        // T5: reset mid-read, then a clean read
        joystick = {16'h0020, 16'h0011};
        do_latch(8'h7E, 8'hFD, 24'hEFFD7E, "t5_latch");
        for (int k = 0; k < 3; k++) do_pulse("t5_pulse_pre");
        do_reset("t5_reset_abort");
        do_latch(8'h7E, 8'hFD, 24'hEFFD7E, "t5_relatch");
        for (int k = 0; k < 9; k++) do_pulse("t5_pulse_post");

        // T6: random reads with off-grid latch/pulse timing
        jitter = 1'b1;
        for (int r = 0; r < 100; r++) begin
            joystick = $urandom();
            turbo_en = 2'($urandom_range(0, 3));
            ph = ((falls / 2) % 2) == 1;
            e0 = ~pad_model(joystick[15:0], ph, turbo_en[0]);
            e1 = ~pad_model(joystick[31:16], ph, turbo_en[1]);
            do_latch(e0, e1, {8'hEF, e1, e0}, "t6_latch");
            np = $urandom_range(0, 26);
            for (int k = 0; k < np; k++) do_pulse("t6_pulse");
        end

        hold(4);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "time limit");
    end

endmodule
